// File: rtl/wb_ddr_pkg.sv
// Shared types and constants for the Wishbone DDR read cache.
package wb_ddr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_ddr_rdcache_mem.sv
// Tag, valid and data arrays for the direct-mapped cache: combinational
// lookup, synchronous byte-enabled writes, valid bits cleared by reset or
// invalidate.
module wb_ddr_rdcache_mem #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             tag_we,
  input  logic             val_set,
  input  logic             inv_clr
);

  localparam int LINES = 1 << IDX_W;

  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  assign rd_data = data_mem[rd_idx];
  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  // Valid bits: invalidate takes priority over a same-edge fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (inv_clr) begin
      valid <= '0;
    end else if (val_set) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Data bytes and tags are written without reset; validity gates their use.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (tag_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/wb_ddr_rdcache.sv
// Direct-mapped single-word read cache with write-through between a CPU
// Wishbone master and a DDR Wishbone slave. Hits answer in one edge; misses
// and writes become single DDR cycles separated by at least one idle cycle.
module wb_ddr_rdcache
  import wb_ddr_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             s_cyc_i,
  input  logic             s_stb_i,
  input  logic             s_we_i,
  input  logic [3:0]       s_sel_i,
  input  logic [31:0]      s_adr_i,
  input  logic [31:0]      s_dat_i,
  output logic [31:0]      s_dat_o,
  output logic             s_ack_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [3:0]       m_sel_o,
  output logic [31:0]      m_adr_o,
  output logic [31:0]      m_dat_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  input  logic             inv_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [TAG_W-1:0] tag_r, tag_n;
  logic             hit_r, hit_n;
  logic             inv_pend, inv_pend_n;
  logic             ack_n, cyc_n, stb_n, we_n;
  logic [31:0]      sdat_n, adr_n, mdat_n;
  logic [3:0]       sel_n;
  logic [CNT_W-1:0] hit_cnt_n, miss_cnt_n;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req, hit;
  logic [31:0]      rd_data, wr_data;
  logic [3:0]       wr_be;
  logic             tag_we, val_set, inv_clr;

  assign req_idx = s_adr_i[IDX_W+1:2];
  assign req_tag = s_adr_i[ADDR_W-1:IDX_W+2];
  assign req     = s_cyc_i & s_stb_i & ~s_ack_o;
  assign wr_data = (state == WR_THRU) ? m_dat_o : m_dat_i;

  wb_ddr_rdcache_mem #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_mem (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .rd_idx  (req_idx),
    .rd_tag  (req_tag),
    .rd_hit  (hit),
    .rd_data (rd_data),
    .wr_idx  (idx_r),
    .wr_tag  (tag_r),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .tag_we  (tag_we),
    .val_set (val_set),
    .inv_clr (inv_clr)
  );

  // Next-state, registered-output and array-control decisions.
  always_comb begin
    state_n    = state;
    idx_n      = idx_r;
    tag_n      = tag_r;
    hit_n      = hit_r;
    inv_pend_n = inv_pend;
    ack_n      = 1'b0;
    sdat_n     = s_dat_o;
    cyc_n      = m_cyc_o;
    stb_n      = m_stb_o;
    we_n       = m_we_o;
    sel_n      = m_sel_o;
    adr_n      = m_adr_o;
    mdat_n     = m_dat_o;
    hit_cnt_n  = hit_cnt_o;
    miss_cnt_n = miss_cnt_o;
    wr_be      = 4'h0;
    tag_we     = 1'b0;
    val_set    = 1'b0;
    inv_clr    = 1'b0;

    if (inv_i && state != IDLE) begin
      inv_pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (inv_i) begin
          if (req) inv_pend_n = 1'b1;
          else     inv_clr    = 1'b1;
        end
        if (req) begin
          idx_n = req_idx;
          tag_n = req_tag;
          if (s_we_i) begin
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b1;
            sel_n   = s_sel_i;
            adr_n   = s_adr_i;
            mdat_n  = s_dat_i;
            hit_n   = hit;
            state_n = WR_THRU;
          end else if (hit) begin
            sdat_n  = rd_data;
            ack_n   = 1'b1;
            if (hit_cnt_o != '1) hit_cnt_n = hit_cnt_o + 1'b1;
            state_n = ACK;
          end else begin
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b0;
            sel_n   = SEL_ALL;
            adr_n   = {s_adr_i[31:2], 2'b00};
            if (miss_cnt_o != '1) miss_cnt_n = miss_cnt_o + 1'b1;
            state_n = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        if (m_ack_i) begin
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          wr_be   = SEL_ALL;
          tag_we  = 1'b1;
          val_set = 1'b1;
          sdat_n  = m_dat_i;
          ack_n   = 1'b1;
          state_n = ACK;
        end
      end
      WR_THRU: begin
        if (m_ack_i) begin
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          if (hit_r) wr_be = m_sel_o;
          ack_n   = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        if (inv_pend || inv_i) begin
          inv_clr    = 1'b1;
          inv_pend_n = 1'b0;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bus outputs and counters, all cleared asynchronously by reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      idx_r      <= '0;
      tag_r      <= '0;
      hit_r      <= 1'b0;
      inv_pend   <= 1'b0;
      s_ack_o    <= 1'b0;
      s_dat_o    <= '0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_sel_o    <= '0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      state      <= state_n;
      idx_r      <= idx_n;
      tag_r      <= tag_n;
      hit_r      <= hit_n;
      inv_pend   <= inv_pend_n;
      s_ack_o    <= ack_n;
      s_dat_o    <= sdat_n;
      m_cyc_o    <= cyc_n;
      m_stb_o    <= stb_n;
      m_we_o     <= we_n;
      m_sel_o    <= sel_n;
      m_adr_o    <= adr_n;
      m_dat_o    <= mdat_n;
      hit_cnt_o  <= hit_cnt_n;
      miss_cnt_o <= miss_cnt_n;
    end
  end

endmodule

// File: tb/tb_wb_ddr_rdcache.sv
// Directed testbench for wb_ddr_rdcache with a latency-programmable DDR slave.
module tb_wb_ddr_rdcache;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [3:0]  s_sel_i = 4'h0;
  logic [31:0] s_adr_i = '0, s_dat_i = '0;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        inv_i = 1'b0;
  logic [15:0] hit_cnt_o, miss_cnt_o;

  int checks = 0;
  int fails  = 0;

  int          ddr_lat = 2;
  logic [31:0] ddr_data = '0;
  int          acc_cnt = 0, stb_cycles = 0, gap_err = 0, slv_cnt = 0;
  logic        last_we = 1'b0;
  logic [3:0]  last_sel = '0;
  logic [31:0] last_adr = '0, last_dat = '0;

  wb_ddr_rdcache dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .s_cyc_i    (s_cyc_i),
    .s_stb_i    (s_stb_i),
    .s_we_i     (s_we_i),
    .s_sel_i    (s_sel_i),
    .s_adr_i    (s_adr_i),
    .s_dat_i    (s_dat_i),
    .s_dat_o    (s_dat_o),
    .s_ack_o    (s_ack_o),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_sel_o    (m_sel_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack_i),
    .inv_i      (inv_i),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // DDR slave: acks after ddr_lat strobe cycles, logs each access and
  // flags a strobe that stays high straight after an acknowledge.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (m_ack_i) begin
        m_ack_i = 1'b0;
        slv_cnt = 0;
        if (m_stb_o) gap_err++;
      end else if (m_cyc_o && m_stb_o) begin
        if (slv_cnt == 0) begin
          acc_cnt++;
          last_we  = m_we_o;
          last_sel = m_sel_o;
          last_adr = m_adr_o;
          last_dat = m_dat_o;
        end
        slv_cnt++;
        stb_cycles++;
        if (slv_cnt >= ddr_lat) begin
          m_ack_i = 1'b1;
          m_dat_i = ddr_data;
        end
      end else begin
        slv_cnt = 0;
      end
    end
  end

  // One CPU access; lat counts edges from request to ack, -1 on timeout.
  task automatic cpu_access(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            output logic [31:0] rdata, output int lat);
    repeat (2) @(negedge wb_clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = adr;  s_dat_i = dat;  s_sel_i = sel;
    lat = 0;
    do begin
      @(posedge wb_clk_i); #1;
      lat++;
    end while (!s_ack_o && lat < 100);
    rdata = s_dat_o;
    if (!s_ack_o) lat = -1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ack: got %b expected 0", s_ack_o); end
    checks++; if (s_dat_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_s_dat: got %h expected 0", s_dat_o); end
    checks++; if ({m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== 7'h0) begin fails++; $display("[TB] FAIL reset_m_ctl: got %b expected 0", {m_cyc_o, m_stb_o, m_we_o, m_sel_o}); end
    checks++; if ({m_adr_o, m_dat_o} !== 64'h0) begin fails++; $display("[TB] FAIL reset_m_adr_dat: got %h expected 0", {m_adr_o, m_dat_o}); end
    checks++; if ({hit_cnt_o, miss_cnt_o} !== 32'h0) begin fails++; $display("[TB] FAIL reset_counters: got %h expected 0", {hit_cnt_o, miss_cnt_o}); end
    wb_rst_i = 1'b0;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat;
    ddr_lat = 5; ddr_data = 32'hDEAD_BEEF; stb_cycles = 0;
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL cold_data: got %h expected deadbeef", rd); end
    checks++; if (lat !== 6) begin fails++; $display("[TB] FAIL cold_latency: got %0d expected 6", lat); end
    checks++; if (stb_cycles !== 5) begin fails++; $display("[TB] FAIL cold_stb_cycles: got %0d expected 5", stb_cycles); end
    checks++; if ({last_we, last_sel, last_adr} !== {1'b0, 4'hF, 32'h0000_0100}) begin fails++; $display("[TB] FAIL cold_ddr_req: got %b %h %h expected 0 f 00000100", last_we, last_sel, last_adr); end
    checks++; if (miss_cnt_o !== 16'd1) begin fails++; $display("[TB] FAIL cold_miss_cnt: got %0d expected 1", miss_cnt_o); end
    @(posedge wb_clk_i); #1;
    checks++; if (s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL cold_ack_width: got %b expected 0", s_ack_o); end
  endtask

  task automatic test_hit_read();
    logic [31:0] rd; int lat, acc0;
    acc0 = acc_cnt;
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL hit_data: got %h expected deadbeef", rd); end
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL hit_latency: got %0d expected 1", lat); end
    checks++; if (acc_cnt !== acc0) begin fails++; $display("[TB] FAIL hit_no_ddr: got %0d accesses expected %0d", acc_cnt, acc0); end
    checks++; if (hit_cnt_o !== 16'd1) begin fails++; $display("[TB] FAIL hit_cnt: got %0d expected 1", hit_cnt_o); end
    @(posedge wb_clk_i); #1;
    checks++; if (s_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL hit_ack_width: got %b expected 0", s_ack_o); end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd; int lat;
    ddr_lat = 2;
    cpu_access(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0011, rd, lat);
    checks++; if (lat !== 3) begin fails++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if ({last_we, last_sel, last_adr, last_dat} !== {1'b1, 4'b0011, 32'h0000_0100, 32'h1122_3344}) begin fails++; $display("[TB] FAIL wr_ddr_req: got %b %b %h %h expected 1 0011 00000100 11223344", last_we, last_sel, last_adr, last_dat); end
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_3344 || lat !== 1) begin fails++; $display("[TB] FAIL wr_merge_hit: got %h lat %0d expected dead3344 lat 1", rd, lat); end
    cpu_access(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, rd, lat);
    checks++; if (last_sel !== 4'b0000 || last_we !== 1'b1) begin fails++; $display("[TB] FAIL wr_sel0_ddr: got we %b sel %b expected 1 0000", last_we, last_sel); end
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_3344) begin fails++; $display("[TB] FAIL wr_sel0_nochange: got %h expected dead3344", rd); end
    checks++; if (hit_cnt_o !== 16'd3 || miss_cnt_o !== 16'd1) begin fails++; $display("[TB] FAIL wr_counters: got hit %0d miss %0d expected 3 1", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int lat;
    ddr_lat = 3;
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL conf_first_hit: got lat %0d expected 1", lat); end
    ddr_data = 32'hCAFE_F00D;
    cpu_access(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hCAFE_F00D || lat !== 4) begin fails++; $display("[TB] FAIL conf_miss_200: got %h lat %0d expected cafef00d lat 4", rd, lat); end
    ddr_data = 32'h55AA_55AA;
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h55AA_55AA || lat !== 4) begin fails++; $display("[TB] FAIL conf_miss_100: got %h lat %0d expected 55aa55aa lat 4", rd, lat); end
    checks++; if (hit_cnt_o !== 16'd4 || miss_cnt_o !== 16'd3) begin fails++; $display("[TB] FAIL conf_counters: got hit %0d miss %0d expected 4 3", hit_cnt_o, miss_cnt_o); end
    cpu_access(1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, rd, lat);
    ddr_data = 32'hA5A5_0001;
    cpu_access(1'b0, 32'h0000_0304, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hA5A5_0001 || miss_cnt_o !== 16'd4) begin fails++; $display("[TB] FAIL wr_no_alloc: got %h miss %0d expected a5a50001 miss 4", rd, miss_cnt_o); end
  endtask

  task automatic test_inv();
    logic [31:0] rd; int lat;
    ddr_lat = 4; ddr_data = 32'h0BAD_F00D; gap_err = 0;
    fork
      cpu_access(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, lat);
      begin
        repeat (3) @(negedge wb_clk_i);
        inv_i = 1'b1;
        @(negedge wb_clk_i);
        inv_i = 1'b0;
      end
    join
    checks++; if (rd !== 32'h0BAD_F00D || lat !== 5) begin fails++; $display("[TB] FAIL inv_fill_ack: got %h lat %0d expected 0badf00d lat 5", rd, lat); end
    ddr_lat = 2; ddr_data = 32'h1111_2222;
    cpu_access(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 3 || miss_cnt_o !== 16'd6) begin fails++; $display("[TB] FAIL inv_same_miss: got lat %0d miss %0d expected 3 6", lat, miss_cnt_o); end
    cpu_access(1'b0, 32'h0000_0304, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 3 || miss_cnt_o !== 16'd7) begin fails++; $display("[TB] FAIL inv_other_miss: got lat %0d miss %0d expected 3 7", lat, miss_cnt_o); end
    repeat (2) @(negedge wb_clk_i);
    inv_i = 1'b1;
    @(negedge wb_clk_i);
    inv_i = 1'b0;
    cpu_access(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 3 || miss_cnt_o !== 16'd8) begin fails++; $display("[TB] FAIL inv_idle_miss: got lat %0d miss %0d expected 3 8", lat, miss_cnt_o); end
    checks++; if (gap_err !== 0) begin fails++; $display("[TB] FAIL stb_gap: got %0d violations expected 0", gap_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat;
    ddr_lat = 10;
    @(negedge wb_clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 32'h0000_0400;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (m_stb_o !== 1'b1) begin fails++; $display("[TB] FAIL mid_stb_before: got %b expected 1", m_stb_o); end
    wb_rst_i = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    #1;
    checks++; if ({m_cyc_o, m_stb_o, s_ack_o} !== 3'b000) begin fails++; $display("[TB] FAIL mid_reset_ctl: got %b expected 000", {m_cyc_o, m_stb_o, s_ack_o}); end
    checks++; if ({hit_cnt_o, miss_cnt_o} !== 32'h0) begin fails++; $display("[TB] FAIL mid_reset_cnt: got %h expected 0", {hit_cnt_o, miss_cnt_o}); end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    ddr_lat = 2; ddr_data = 32'h7777_8888;
    cpu_access(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h7777_8888 || lat !== 3) begin fails++; $display("[TB] FAIL mid_next_miss: got %h lat %0d expected 77778888 lat 3", rd, lat); end
    checks++; if (miss_cnt_o !== 16'd1 || hit_cnt_o !== 16'd0) begin fails++; $display("[TB] FAIL mid_counters: got hit %0d miss %0d expected 0 1", hit_cnt_o, miss_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_hit_read();
    test_write_merge();
    test_conflict();
    test_inv();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
